// File: rtl/rr_grant_scheduler_if.sv
// Request/grant bundle between requesters (master) and the round-robin scheduler (slave).
interface rr_grant_scheduler_if;
    localparam int unsigned N_REQ = 8;
    localparam int unsigned IDX_W = 3;

    logic              enb;
    logic [N_REQ-1:0]  req;
    logic              rel;
    logic [N_REQ-1:0]  gnt;
    logic [IDX_W-1:0]  gnt_idx;
    logic              gnt_vld;
    logic              tmo;

    modport master (output enb, req, rel, input gnt, gnt_idx, gnt_vld, tmo);
    modport slave  (input enb, req, rel, output gnt, gnt_idx, gnt_vld, tmo);
endinterface

// File: rtl/rr_grant_scheduler.sv
// Eight-way round-robin grant scheduler with a bounded hold time and a one-cycle
// idle gap between successive grants.
module rr_grant_scheduler #(
    parameter int unsigned HOLD_MAX = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rr_grant_scheduler_if.slave  bus
);
    localparam int unsigned N_REQ = 8;
    localparam int unsigned IDX_W = 3;
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    logic [1:0]       state_q,  state_d;
    logic [N_REQ-1:0] gnt_q,    gnt_d;
    logic [IDX_W-1:0] idx_q,    idx_d;
    logic             vld_q,    vld_d;
    logic             tmo_q,    tmo_d;
    logic [CNT_W-1:0] hold_q,   hold_d;
    logic [IDX_W-1:0] last_q,   last_d;

    logic [IDX_W-1:0] cand;
    logic [IDX_W-1:0] win_idx;
    logic             win_found;
    logic             holder_req;
    logic             others_req;
    logic             hold_expired;

    // Lowest rotated position wins: scan downward so the nearest candidate is written last.
    always_comb begin
        cand      = '0;
        win_idx   = last_q;
        win_found = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = last_q + IDX_W'(k) + IDX_W'(1);
            if (bus.req[cand]) begin
                win_idx   = cand;
                win_found = 1'b1;
            end
        end
    end

    assign holder_req   = bus.req[idx_q];
    assign others_req   = |(bus.req & ~gnt_q);
    assign hold_expired = (hold_q == HOLD_LAST) && others_req;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        vld_d   = vld_q;
        tmo_d   = 1'b0;
        hold_d  = hold_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE, ST_GAP: begin
                if (bus.enb && win_found) begin
                    state_d = ST_GRANT;
                    gnt_d   = N_REQ'(1) << win_idx;
                    idx_d   = win_idx;
                    vld_d   = 1'b1;
                    last_d  = win_idx;
                    hold_d  = '0;
                end else begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                    vld_d   = 1'b0;
                end
            end
            ST_GRANT: begin
                if (bus.rel || !holder_req || hold_expired) begin
                    state_d = ST_GAP;
                    gnt_d   = '0;
                    vld_d   = 1'b0;
                    hold_d  = '0;
                    tmo_d   = !bus.rel && holder_req;
                end else if (hold_q != HOLD_LAST) begin
                    hold_d  = hold_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                vld_d   = 1'b0;
                hold_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            idx_q   <= '0;
            vld_q   <= 1'b0;
            tmo_q   <= 1'b0;
            hold_q  <= '0;
            last_q  <= IDX_W'(N_REQ - 1);
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            vld_q   <= vld_d;
            tmo_q   <= tmo_d;
            hold_q  <= hold_d;
            last_q  <= last_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.gnt_idx = idx_q;
    assign bus.gnt_vld = vld_q;
    assign bus.tmo     = tmo_q;
endmodule

// File: doc/rr_grant_scheduler.md
RR_GRANT_SCHEDULER -- requirements
Module: rr_grant_scheduler

Interface
REQ-001 The block SHALL have one parameter: HOLD_MAX, default 8, the maximum number of consecutive grant cycles (legal range 1..15) one requester may keep while others are waiting.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 enb  input  1  arbitration enable; when low, no new grant is issued.
REQ-005 req  input  8  request vector; bit i high means requester i wants the shared resource.
REQ-006 rel  input  1  release strobe from the current grant holder.
REQ-007 gnt  output  8  one-hot grant vector, registered; all-zero when no grant is active.
REQ-008 gnt_idx  output  3  binary index of the granted requester; valid only while gnt_vld is high.
REQ-009 gnt_vld  output  1  high exactly when gnt is non-zero.
REQ-010 tmo  output  1  one-cycle pulse marking a forced (timeout) release.

Function
REQ-011 The FSM SHALL have three states: IDLE, GRANT and GAP.
REQ-012 In IDLE or GAP, the block SHALL arbitrate when enb=1 and req!=0: the winner is the first set req bit searched upward from (last_idx+1) mod 8, wrapping 7->0.
REQ-013 A winner chosen in IDLE or GAP SHALL be granted the next cycle: state GRANT, gnt = one-hot of winner (bit i for index i, matching the 3-to-8 decode), gnt_idx = winner, gnt_vld=1, last_idx = winner, hold_cnt=0.
REQ-014 Grant latency SHALL be 1 cycle: req sampled at edge N produces gnt at edge N+1.
REQ-015 With enb=0 or req=0 in IDLE or GAP, the block SHALL go to (or stay in) IDLE with gnt=0.
REQ-016 In GRANT, hold_cnt SHALL increment every cycle and saturate at HOLD_MAX-1.
REQ-017 GRANT SHALL exit to GAP (gnt=0 for the next cycle) when any of these holds: rel=1; req[gnt_idx]=0; or hold_cnt==HOLD_MAX-1 while any other req bit is set.
REQ-018 When the holder is the only requester, hitting hold_cnt==HOLD_MAX-1 SHALL NOT end the grant; it is held indefinitely until rel or the request drops.
REQ-019 tmo SHALL be 1 for the first GAP cycle only when the exit cause was timeout alone (neither rel nor req drop in the same cycle), and 0 otherwise.
REQ-020 GAP SHALL last exactly one cycle with all grants low, so a hand-off is: rel at edge N, gnt=0 during cycle N+1, new gnt at edge N+2.
REQ-021 enb going low during GRANT SHALL NOT revoke the current grant; it only blocks the next arbitration.
REQ-022 rel asserted while not in GRANT SHALL be ignored.
REQ-023 gnt SHALL never have more than one bit set, and gnt_idx SHALL hold its last value while gnt_vld=0.

Reset
REQ-024 When rst_n=0, the block SHALL immediately, without waiting for a clock edge, set: state=IDLE, gnt=0, gnt_vld=0, gnt_idx=0, tmo=0, hold_cnt=0, last_idx=7 (first priority goes to requester 0).
REQ-025 Reset asserted mid-grant SHALL drop gnt asynchronously; after rst_n rises, arbitration SHALL restart from requester 0 on the first edge with enb=1.

Verification
REQ-026 Reset, enb=1, req=8'b1000_0001 -> gnt=8'b0000_0001, gnt_idx=0 one cycle later.
REQ-027 Rotation: all req=8'hFF, holder pulses rel each grant -> grants go 0,1,2,...,7,0 with exactly one zero-gnt cycle between grants.
REQ-028 Timeout: HOLD_MAX=4, req=8'h03, no rel -> gnt=8'h01 for exactly 4 cycles, GAP with tmo=1, then gnt=8'h02.
REQ-029 Sole holder: HOLD_MAX=4, req=8'h04 only, no rel for 20 cycles -> gnt=8'h04 held for all 20 cycles, tmo stays 0.
REQ-030 enb=0 with req=8'hFF -> gnt stays 0; enb dropped mid-grant -> grant continues until rel, then gnt=0 and stays 0.
REQ-031 rst_n pulsed low while gnt=8'h20 -> gnt=0 before the next edge; after reset with req=8'hFF -> gnt=8'h01.
